// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: ctrl encodings, FSM states, default width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 64;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic logic ctrl_legal(input logic [3:0] c);
    logic ok;
    case (c)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR: ok = 1'b1;
      default:                                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Classic 1-bit ALU slice: optional operand inversion, AND/OR/ADD/LESS select,
// full-adder carry and raw sum exposed as set.
module alu_bit_slice (
  input  logic       a,
  input  logic       b,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic [1:0] op,
  input  logic       cin,
  input  logic       less,
  output logic       o,
  output logic       set,
  output logic       cout
);

  logic aa;
  logic bb;
  logic sum;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ binvert;
  assign sum  = aa ^ bb ^ cin;
  assign cout = (aa & bb) | (aa & cin) | (bb & cin);
  assign set  = sum;

  always_comb begin
    o = 1'b0;
    case (op)
      2'b00:   o = aa & bb;
      2'b01:   o = aa | bb;
      2'b10:   o = sum;
      default: o = less;
    endcase
  end

endmodule

// File: rtl/serial_alu64.sv
// Bit-serial ALU: one alu_bit_slice iterated LSB-first over WIDTH bits with a start/done handshake.
// SERIAL_ALU_SLT_OVF_FIX_EN: when defined, SLT corrects the sign bit for subtraction overflow.
module serial_alu64
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sh_q, result_q;
  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, ill_q, zero_q, cout_q, ovf_q, err_q;

  logic             s_o, s_set, s_cout;
  logic             accept, last;
  logic             ovf_raw, less_bit;
  logic [WIDTH-1:0] shifted, fin_res;
  logic             fin_cout, fin_ovf;

  alu_bit_slice u_slice (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .ainvert (ctrl_q[3]),
    .binvert (ctrl_q[2]),
    .op      (ctrl_q[1:0]),
    .cin     (carry_q),
    .less    (1'b0),
    .o       (s_o),
    .set     (s_set),
    .cout    (s_cout)
  );

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last   = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // On the final bit the slice is evaluating the MSB, so carry_q is the carry into it.
  assign ovf_raw = carry_q ^ s_cout;
`ifdef SERIAL_ALU_SLT_OVF_FIX_EN
  assign less_bit = s_set ^ ovf_raw;
`else
  assign less_bit = s_set;
`endif
  assign shifted = {s_o, sh_q[WIDTH-1:1]};

  always_comb begin
    fin_res  = shifted;
    fin_cout = s_cout;
    fin_ovf  = ovf_raw;
    if (ill_q) begin
      fin_res  = '0;
      fin_cout = 1'b0;
      fin_ovf  = 1'b0;
    end else begin
      case (ctrl_q)
        CTRL_SLT: begin
          fin_res    = '0;
          fin_res[0] = less_bit;
        end
        CTRL_AND, CTRL_OR, CTRL_NOR: begin
          fin_cout = 1'b0;
          fin_ovf  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ill_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sh_q    <= '0;
      ctrl_q  <= ctrl;
      cnt_q   <= '0;
      carry_q <= ctrl[2];
      ill_q   <= !ctrl_legal(ctrl);
    end else if (state_q == S_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sh_q    <= shifted;
      carry_q <= s_cout;
      if (last) begin
        result_q <= fin_res;
        zero_q   <= (fin_res == '0);
        cout_q   <= fin_cout;
        ovf_q    <= fin_ovf;
        err_q    <= ill_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule
